// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: FSM state encoding and address-field width helpers for the L1 data cache.
package l1_cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL_REQ,
      FILL_GAP,
      WRITE_THRU,
      RESP,
      WAIT
   } state_t;

   function automatic int byte_w(int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int off_w(int block_size);
      return $clog2(block_size);
   endfunction

   function automatic int idx_w(int cache_size, int block_size);
      return $clog2(cache_size / block_size);
   endfunction

   function automatic int wsel_w(int block_size, int data_width);
      return $clog2(block_size / (data_width / 8));
   endfunction

   function automatic int tag_w(int addr_width, int cache_size);
      return addr_width - $clog2(cache_size);
   endfunction

endpackage

// File: rtl/l1_cache_if.sv
// l1_cache_if: CPU-side and L2-side bus bundles of the L1 data cache.
interface l1_cache_cpu_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  read;
   logic                  write;
   logic                  ready;
   logic                  hit;

   modport master (output addr, wdata, read, write, input rdata, ready, hit);
   modport slave  (input addr, wdata, read, write, output rdata, ready, hit);
endinterface

interface l1_cache_l2_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  read;
   logic                  write;
   logic                  ready;

   modport master (output addr, wdata, read, write, input rdata, ready);
   modport slave  (input addr, wdata, read, write, output rdata, ready);
endinterface

// File: rtl/l1_line_store.sv
// l1_line_store: tag/valid/data arrays with combinational lookup and synchronous word write / line install.
module l1_line_store
   import l1_cache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CACHE_SIZE = 256,
   parameter int BLOCK_SIZE = 16,
   localparam int BW = byte_w(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_WIDTH-1:BW]   i_look_addr,
   output logic                     o_hit,
   output logic [DATA_WIDTH-1:0]    o_rdata,
   input  logic [ADDR_WIDTH-1:BW]   i_wr_addr,
   input  logic                     i_we,
   input  logic [DATA_WIDTH-1:0]    i_wdata,
   input  logic                     i_install,
   input  logic                     i_invalidate
);
   localparam int OFF_W  = off_w(BLOCK_SIZE);
   localparam int IDX_W  = idx_w(CACHE_SIZE, BLOCK_SIZE);
   localparam int TAG_W  = tag_w(ADDR_WIDTH, CACHE_SIZE);
   localparam int LINES  = CACHE_SIZE / BLOCK_SIZE;
   localparam int WORDS  = BLOCK_SIZE / (DATA_WIDTH / 8);

   logic [TAG_W-1:0]      r_tag  [LINES];
   logic [DATA_WIDTH-1:0] r_data [LINES][WORDS];
   logic [LINES-1:0]      r_valid;

   logic [IDX_W-1:0]      w_l_idx, w_w_idx;
   logic [OFF_W-BW-1:0]   w_l_sel, w_w_sel;
   logic [TAG_W-1:0]      w_l_tag, w_w_tag;

   assign w_l_sel = i_look_addr[OFF_W-1:BW];
   assign w_l_idx = i_look_addr[OFF_W+IDX_W-1:OFF_W];
   assign w_l_tag = i_look_addr[ADDR_WIDTH-1:OFF_W+IDX_W];
   assign w_w_sel = i_wr_addr[OFF_W-1:BW];
   assign w_w_idx = i_wr_addr[OFF_W+IDX_W-1:OFF_W];
   assign w_w_tag = i_wr_addr[ADDR_WIDTH-1:OFF_W+IDX_W];

   assign o_hit   = r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag);
   assign o_rdata = r_data[w_l_idx][w_l_sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_valid <= '0;
      else if (i_install)    r_valid[w_w_idx] <= 1'b1;
      else if (i_invalidate) r_valid[w_w_idx] <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (i_we)      r_data[w_w_idx][w_w_sel] <= i_wdata;
      if (i_install) r_tag[w_w_idx] <= w_w_tag;
   end

endmodule

// File: rtl/l1_cache.sv
// l1_cache: direct-mapped write-through, no-write-allocate L1 data cache.
// Read misses fill the whole block from L2 word by word; every store is forwarded to L2.
module l1_cache
   import l1_cache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CACHE_SIZE = 256,
   parameter int BLOCK_SIZE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   l1_cache_cpu_if.slave    cpu,
   l1_cache_l2_if.master    l2
);
   localparam int BW     = byte_w(DATA_WIDTH);
   localparam int OFF_W  = off_w(BLOCK_SIZE);
   localparam int WSEL_W = wsel_w(BLOCK_SIZE, DATA_WIDTH);
   localparam int WORDS  = BLOCK_SIZE / (DATA_WIDTH / 8);

   state_t                r_state;
   logic [ADDR_WIDTH-1:BW] r_addr;
   logic [WSEL_W-1:0]     r_cnt;
   logic                  r_hit;
   logic                  r_is_wr;
   logic                  r_cpu_ready;
   logic                  r_cpu_hit;
   logic [DATA_WIDTH-1:0] r_cpu_rdata;
   logic [ADDR_WIDTH-1:0] r_l2_addr;
   logic [DATA_WIDTH-1:0] r_l2_wdata;
   logic                  r_l2_read;
   logic                  r_l2_write;

   logic                  w_idle;
   logic                  w_hit;
   logic                  w_last;
   logic                  w_we;
   logic                  w_install;
   logic                  w_inv;
   logic                  w_unused;
   logic [ADDR_WIDTH-1:BW] w_look;
   logic [ADDR_WIDTH-1:BW] w_wa;
   logic [DATA_WIDTH-1:0] w_rd;
   logic [DATA_WIDTH-1:0] w_wdata;

   assign w_unused  = ^cpu.addr[BW-1:0];
   assign w_idle    = (r_state == IDLE);
   assign w_last    = (r_cnt == WSEL_W'(WORDS - 1));
   // In IDLE the arrays are addressed by the live request, otherwise by the latched one.
   assign w_look    = w_idle ? cpu.addr[ADDR_WIDTH-1:BW] : r_addr;
   assign w_wa      = w_idle ? cpu.addr[ADDR_WIDTH-1:BW] : {r_addr[ADDR_WIDTH-1:OFF_W], r_cnt};
   assign w_wdata   = w_idle ? cpu.wdata : l2.rdata;
   assign w_we      = (w_idle && cpu.write && w_hit) || (r_state == FILL_REQ && l2.ready);
   assign w_install = (r_state == FILL_REQ) && l2.ready && w_last;
   // A fill overwrites the line word by word, so the old contents must stop hitting at once.
   assign w_inv     = w_idle && cpu.read && !cpu.write && !w_hit;

   assign cpu.rdata = r_cpu_rdata;
   assign cpu.ready = r_cpu_ready;
   assign cpu.hit   = r_cpu_hit;
   assign l2.addr   = r_l2_addr;
   assign l2.wdata  = r_l2_wdata;
   assign l2.read   = r_l2_read;
   assign l2.write  = r_l2_write;

   l1_line_store #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CACHE_SIZE (CACHE_SIZE),
      .BLOCK_SIZE (BLOCK_SIZE)
   ) u_store (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_look_addr  (w_look),
      .o_hit        (w_hit),
      .o_rdata      (w_rd),
      .i_wr_addr    (w_wa),
      .i_we         (w_we),
      .i_wdata      (w_wdata),
      .i_install    (w_install),
      .i_invalidate (w_inv)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_hit       <= 1'b0;
         r_is_wr     <= 1'b0;
         r_cpu_ready <= 1'b0;
         r_cpu_hit   <= 1'b0;
         r_cpu_rdata <= '0;
         r_l2_addr   <= '0;
         r_l2_wdata  <= '0;
         r_l2_read   <= 1'b0;
         r_l2_write  <= 1'b0;
      end else begin
         r_cpu_ready <= 1'b0;
         r_cpu_hit   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cpu.write || cpu.read) begin
                  r_addr  <= cpu.addr[ADDR_WIDTH-1:BW];
                  r_hit   <= w_hit;
                  r_is_wr <= cpu.write;
               end
               if (cpu.write) begin
                  r_l2_write <= 1'b1;
                  r_l2_addr  <= {cpu.addr[ADDR_WIDTH-1:BW], {BW{1'b0}}};
                  r_l2_wdata <= cpu.wdata;
                  r_state    <= WRITE_THRU;
               end else if (cpu.read && w_hit) begin
                  r_state <= RESP;
               end else if (cpu.read) begin
                  r_cnt     <= '0;
                  r_l2_read <= 1'b1;
                  r_l2_addr <= {cpu.addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                  r_state   <= FILL_REQ;
               end
            end
            FILL_REQ: begin
               if (l2.ready) begin
                  r_l2_read <= 1'b0;
                  r_cnt     <= w_last ? r_cnt : r_cnt + WSEL_W'(1);
                  r_state   <= w_last ? RESP : FILL_GAP;
               end
            end
            FILL_GAP: begin
               r_l2_read <= 1'b1;
               r_l2_addr <= {r_addr[ADDR_WIDTH-1:OFF_W], r_cnt, {BW{1'b0}}};
               r_state   <= FILL_REQ;
            end
            WRITE_THRU: begin
               if (l2.ready) begin
                  r_l2_write <= 1'b0;
                  r_state    <= RESP;
               end
            end
            RESP: begin
               r_cpu_ready <= 1'b1;
               r_cpu_hit   <= r_hit;
               if (!r_is_wr) r_cpu_rdata <= w_rd;
               r_state     <= WAIT;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_cache.sv
// tb_l1_cache: directed test of l1_cache against a 2-cycle-latency L2 model.
module tb_l1_cache;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   l1_cache_cpu_if cpu_if ();
   l1_cache_l2_if  l2_if ();

   l1_cache dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cpu   (cpu_if),
      .l2    (l2_if)
   );

   int n_chk = 0;
   int n_fail = 0;
   int l2_cnt = 0;
   bit both_seen = 0;
   bit poke = 0;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] tx_a [$];
   logic [31:0] tx_d [$];
   bit          tx_w [$];

   logic [31:0] rd;
   logic        h;
   int          cyc;
   int          base;
   bit          rdy_in_rst;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // L2 model: ready pulses two cycles after a strobe is seen; writes update its memory.
   initial begin
      l2_if.ready = 1'b0;
      l2_if.rdata = '0;
      forever begin
         @(posedge clk); #1;
         l2_if.ready = 1'b0;
         if (l2_if.read && l2_if.write) both_seen = 1;
         if (poke) begin
            l2_if.ready = 1'b1;
            poke = 0;
         end else if (l2_if.read || l2_if.write) begin
            l2_cnt++;
            if (l2_cnt == 2) begin
               l2_cnt = 0;
               l2_if.ready = 1'b1;
               tx_a.push_back(l2_if.addr);
               tx_w.push_back(l2_if.write);
               tx_d.push_back(l2_if.wdata);
               if (l2_if.write) mem[l2_if.addr] = l2_if.wdata;
               else l2_if.rdata = mem.exists(l2_if.addr) ? mem[l2_if.addr]
                                                         : 32'hA0 + ((l2_if.addr - 32'h40) >> 2);
            end
         end else begin
            l2_cnt = 0;
         end
      end
   end

   task automatic cpu_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] o_rd, output logic o_h, output int o_cyc);
      cpu_if.addr  = a;
      cpu_if.wdata = d;
      cpu_if.read  = !wr;
      cpu_if.write = wr;
      o_cyc = 0;
      do begin
         @(posedge clk); #1;
         o_cyc++;
      end while (!cpu_if.ready && o_cyc < 100);
      check("ready_seen", cpu_if.ready, 1);
      o_rd = cpu_if.rdata;
      o_h  = cpu_if.hit;
      cpu_if.read  = 1'b0;
      cpu_if.write = 1'b0;
      @(posedge clk); #1;
      check("ready_pulse", cpu_if.ready, 0);
      check("hit_idle", cpu_if.hit, 0);
   endtask

   task automatic expect_tx(input string tag, input int b, input int n, input logic [31:0] a0, input bit wr);
      check({tag, "_count"}, tx_a.size() - b, n);
      for (int i = 0; i < n && b + i < tx_a.size(); i++) begin
         check({tag, "_addr"}, tx_a[b+i], a0 + 32'(4 * i));
         check({tag, "_kind"}, tx_w[b+i], wr);
      end
   endtask

   initial begin
      cpu_if.addr  = '0;
      cpu_if.wdata = '0;
      cpu_if.read  = 1'b0;
      cpu_if.write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", cpu_if.ready, 0);
      check("rst_hit", cpu_if.hit, 0);
      check("rst_rdata", cpu_if.rdata, 0);
      check("rst_l2_read", l2_if.read, 0);
      check("rst_l2_write", l2_if.write, 0);
      check("rst_l2_addr", l2_if.addr, 0);
      check("rst_l2_wdata", l2_if.wdata, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      base = tx_a.size();
      cpu_op(0, 32'h40, 0, rd, h, cyc);
      check("cold_rdata", rd, 32'hA0);
      check("cold_hit", h, 0);
      check("cold_cycles", cyc, 13);
      expect_tx("cold_fill", base, 4, 32'h40, 0);

      base = tx_a.size();
      cpu_op(0, 32'h48, 0, rd, h, cyc);
      check("hit_rdata", rd, 32'hA2);
      check("hit_hit", h, 1);
      check("hit_cycles", cyc, 2);
      check("hit_no_l2", tx_a.size() - base, 0);

      base = tx_a.size();
      cpu_op(1, 32'h44, 32'hDEADBEEF, rd, h, cyc);
      check("wr_hit_hit", h, 1);
      check("wr_hit_cycles", cyc, 4);
      check("wr_keeps_rdata", rd, 32'hA2);
      expect_tx("wr_hit", base, 1, 32'h44, 1);
      if (tx_d.size() > base) check("wr_hit_data", tx_d[base], 32'hDEADBEEF);
      else check("wr_hit_data_present", tx_d.size(), base + 1);
      base = tx_a.size();
      cpu_op(0, 32'h44, 0, rd, h, cyc);
      check("rd_after_wr", rd, 32'hDEADBEEF);
      check("rd_after_wr_hit", h, 1);
      check("rd_after_wr_no_l2", tx_a.size() - base, 0);

      base = tx_a.size();
      cpu_op(1, 32'h1000, 32'h12345678, rd, h, cyc);
      check("wr_miss_hit", h, 0);
      expect_tx("wr_miss", base, 1, 32'h1000, 1);
      base = tx_a.size();
      cpu_op(0, 32'h1000, 0, rd, h, cyc);
      check("no_alloc_hit", h, 0);
      check("no_alloc_rdata", rd, 32'h12345678);
      expect_tx("no_alloc_fill", base, 4, 32'h1000, 0);

      base = tx_a.size();
      cpu_op(0, 32'h140, 0, rd, h, cyc);
      check("conflict_rdata", rd, 32'hE0);
      check("conflict_hit", h, 0);
      expect_tx("conflict_fill", base, 4, 32'h140, 0);
      base = tx_a.size();
      cpu_op(0, 32'h40, 0, rd, h, cyc);
      check("evicted_rdata", rd, 32'hA0);
      check("evicted_hit", h, 0);
      expect_tx("evicted_fill", base, 4, 32'h40, 0);

      cpu_op(0, 32'hF0, 0, rd, h, cyc);
      check("top_line_rdata", rd, 32'hCC);
      check("top_line_miss", h, 0);
      cpu_op(0, 32'hFC, 0, rd, h, cyc);
      check("top_line_hit_rdata", rd, 32'hCF);
      check("top_line_hit", h, 1);

      poke = 1;
      repeat (3) @(posedge clk);
      #1;
      check("spurious_ready", cpu_if.ready, 0);
      check("spurious_strobe", l2_if.read | l2_if.write, 0);
      cpu_op(0, 32'h48, 0, rd, h, cyc);
      check("after_spurious_rdata", rd, 32'hA2);
      check("after_spurious_cycles", cyc, 2);

      base = tx_a.size();
      cpu_if.addr = 32'h200;
      cpu_if.read = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #2;
         cyc++;
      end while (!(tx_a.size() - base == 2 && l2_if.read) && cyc < 60);
      check("third_beat_reached", cyc < 60, 1);
      rst_n = 1'b0;
      cpu_if.read = 1'b0;
      #1;
      check("abort_l2_read", l2_if.read, 0);
      check("abort_l2_write", l2_if.write, 0);
      rdy_in_rst = 0;
      repeat (3) begin
         @(posedge clk); #1;
         rdy_in_rst |= cpu_if.ready;
      end
      check("abort_no_ready", rdy_in_rst, 0);
      check("abort_beats", tx_a.size() - base, 2);
      rst_n = 1'b1;
      check("post_rst_rdata", cpu_if.rdata, 0);
      check("post_rst_l2_addr", l2_if.addr, 0);
      @(posedge clk); #1;
      base = tx_a.size();
      cpu_op(0, 32'h200, 0, rd, h, cyc);
      check("refill_rdata", rd, 32'h110);
      check("refill_hit", h, 0);
      check("refill_cycles", cyc, 13);
      expect_tx("refill", base, 4, 32'h200, 0);
      cpu_op(0, 32'h48, 0, rd, h, cyc);
      check("valid_cleared_hit", h, 0);
      check("valid_cleared_rdata", rd, 32'hA2);

      check("strobes_exclusive", both_seen, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
